// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
//   state_t      : responder FSM states (IDLE / REQ / RELEASE)
//   OFF_*        : word offsets of the local MMIO registers inside the window
//   TIMEOUT_DATA : load data returned when the external SRAM never acknowledges
package mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [1:0] OFF_LED  = 2'd0;
    localparam logic [1:0] OFF_SW   = 2'd1;
    localparam logic [1:0] OFF_CNT  = 2'd2;
    localparam logic [1:0] OFF_STAT = 2'd3;

    localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

endpackage

// File: rtl/mem_responder_if.sv
// Bus bundle between the CPU/SRAM side and the memory responder.
//   CPU side : req_re, req_we, req_addr, req_wdata -> responder; rdata, busy <- responder
//   SRAM side: ext_req, ext_we, ext_addr, ext_wdata <- responder; ext_ack, ext_rdata -> responder
// Handshake: the CPU presents a strobe and must hold it while busy=1; the SRAM link
// is 4-phase (ext_req rises, ext_ack rises, ext_req falls, ext_ack falls), with
// ext_we/ext_addr/ext_wdata stable while ext_req=1 and ext_rdata valid while ext_ack=1.
interface mem_responder_if;

    logic        req_re;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [15:0] rdata;
    logic        busy;

    logic        ext_req;
    logic        ext_we;
    logic [15:0] ext_addr;
    logic [15:0] ext_wdata;
    logic        ext_ack;
    logic [15:0] ext_rdata;

    // Responder view.
    modport slave (
        input  req_re, req_we, req_addr, req_wdata, ext_ack, ext_rdata,
        output rdata, busy, ext_req, ext_we, ext_addr, ext_wdata
    );

    // CPU + SRAM view (whoever drives requests and acknowledges).
    modport master (
        output req_re, req_we, req_addr, req_wdata, ext_ack, ext_rdata,
        input  rdata, busy, ext_req, ext_we, ext_addr, ext_wdata
    );

endinterface

// File: rtl/mem_responder_sync2.sv
// Two-flop synchronizer for the asynchronous board switches.
//   clock : sampling clock
//   reset : asynchronous active-low reset, both flops clear to 0
//   d     : asynchronous input
//   q     : synchronized output, two edges behind d
module sync2 #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] ff1;
    logic [WIDTH-1:0] ff2;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ff1 <= '0;
            ff2 <= '0;
        end else begin
            ff1 <= d;
            ff2 <= ff1;
        end
    end

    assign q = ff2;

endmodule

// File: rtl/mem_responder.sv
// Data-memory responder for the multicycle CPU.
// Serves load/store strobes: addresses in the 4-word MMIO window hit local
// registers (LED, switches, cycle counter, status) in one edge; everything else
// goes to external SRAM over a 4-phase req/ack handshake guarded by a timeout.
//   clock, reset : clock and asynchronous active-low reset
//   bus          : CPU request/response and SRAM handshake signals
//   sw_in        : asynchronous switches, read through a 2-flop synchronizer
//   led_out      : LED register
//   dbg_state    : current FSM state
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int          TIMEOUT   = 255,
    parameter logic [15:0] MMIO_BASE = 16'hFFF0
) (
    input  logic             clock,
    input  logic             reset,
    mem_responder_if.slave   bus,
    input  logic [7:0]       sw_in,
    output logic [7:0]       led_out,
    output state_t           dbg_state
);

    localparam int          TW     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);

    state_t        state;
    state_t        state_nxt;

    logic          ext_req_q;
    logic          ext_we_q;
    logic [15:0]   ext_addr_q;
    logic [15:0]   ext_wdata_q;
    logic [TW-1:0] to_cnt;
    logic [15:0]   rdata_q;
    logic [7:0]    led_q;
    logic [15:0]   cyc_cnt;
    logic          err_q;
    logic [7:0]    sw_sync;

    logic          accept;
    logic          mmio_hit;
    logic          mmio_rd;
    logic          mmio_wr;
    logic          start_ext;
    logic          timeout_hit;
    logic [1:0]    off;
    logic [15:0]   mmio_rdata;

    sync2 #(.WIDTH(8)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (sw_in),
        .q     (sw_sync)
    );

    // Requests are only looked at in IDLE; a store strobe wins over a load strobe.
    assign accept      = (state == IDLE) && (bus.req_re || bus.req_we);
    assign mmio_hit    = (bus.req_addr[15:2] == MMIO_BASE[15:2]);
    assign off         = bus.req_addr[1:0];
    assign mmio_wr     = accept && mmio_hit && bus.req_we;
    assign mmio_rd     = accept && mmio_hit && !bus.req_we;
    assign start_ext   = accept && !mmio_hit;
    // An ack on the last allowed edge still completes normally.
    assign timeout_hit = (state == REQ) && !bus.ext_ack && (to_cnt == TO_MAX);

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ext) state_nxt = REQ;
            REQ:     if (bus.ext_ack || timeout_hit) state_nxt = RELEASE;
            RELEASE: if (!bus.ext_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Local register read mux; busy is always 0 when a read can reach here.
    always_comb begin
        mmio_rdata = 16'h0000;
        case (off)
            OFF_LED:  mmio_rdata = {8'h00, led_q};
            OFF_SW:   mmio_rdata = {8'h00, sw_sync};
            OFF_CNT:  mmio_rdata = cyc_cnt;
            OFF_STAT: mmio_rdata = {14'b0, 1'b0, err_q};
            default:  mmio_rdata = 16'h0000;
        endcase
    end

    // External handshake and timeout counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ext_req_q   <= 1'b0;
            ext_we_q    <= 1'b0;
            ext_addr_q  <= 16'h0000;
            ext_wdata_q <= 16'h0000;
            to_cnt      <= '0;
        end else if (start_ext) begin
            ext_req_q   <= 1'b1;
            ext_we_q    <= bus.req_we;
            ext_addr_q  <= bus.req_addr;
            ext_wdata_q <= bus.req_wdata;
            to_cnt      <= '0;
        end else if (state == REQ) begin
            if (bus.ext_ack || timeout_hit) begin
                ext_req_q <= 1'b0;
            end else begin
                to_cnt <= to_cnt + TW'(1);
            end
        end
    end

    // Load data register; stores never touch it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata_q <= 16'h0000;
        end else if (mmio_rd) begin
            rdata_q <= mmio_rdata;
        end else if ((state == REQ) && bus.ext_ack && !ext_we_q) begin
            rdata_q <= bus.ext_rdata;
        end else if (timeout_hit && !ext_we_q) begin
            rdata_q <= TIMEOUT_DATA;
        end
    end

    // MMIO registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            led_q   <= 8'h00;
            cyc_cnt <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            if (mmio_wr && (off == OFF_LED)) begin
                led_q <= bus.req_wdata[7:0];
            end
            // A write clears the counter and takes precedence over the increment.
            if (mmio_wr && (off == OFF_CNT)) begin
                cyc_cnt <= 16'h0000;
            end else begin
                cyc_cnt <= cyc_cnt + 16'h0001;
            end
            // Setting on timeout beats clearing on the same edge.
            if (timeout_hit) begin
                err_q <= 1'b1;
            end else if (mmio_wr && (off == OFF_STAT) && bus.req_wdata[0]) begin
                err_q <= 1'b0;
            end
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.rdata     = rdata_q;
    assign bus.ext_req   = ext_req_q;
    assign bus.ext_we    = ext_we_q;
    assign bus.ext_addr  = ext_addr_q;
    assign bus.ext_wdata = ext_wdata_q;
    assign led_out       = led_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed cases plus randomized traffic
// checked against a behavioural model (register values, edge-indexed switch log,
// cycle counter derived from the edge count since the last clear, SRAM array).
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int TO = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] sw_in;
    logic [7:0] led_out;
    state_t     dbg_state;

    mem_responder_if bus();

    mem_responder #(.TIMEOUT(TO), .MMIO_BASE(16'hFFF0)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .sw_in     (sw_in),
        .led_out   (led_out),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / edge log ----------------
    always #5 clock = ~clock;

    int         cyc = 0;
    logic [7:0] sw_seen [int];

    always @(posedge clock) begin
        cyc = cyc + 1;
        sw_seen[cyc] = sw_in;
    end

    // ---------------- model + scoreboard ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  m_led;
    logic        m_err;
    logic [15:0] m_rdata;
    int          clr_edge;
    int          rst_rel;
    logic [15:0] mem [int];
    logic [15:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Switch value seen by a read at the edge after cb: what was on sw_in two edges earlier.
    function automatic logic [7:0] m_sw(input int cb);
        int idx;
        idx = cb - 1;
        if (idx <= rst_rel || !sw_seen.exists(idx)) return 8'h00;
        return sw_seen[idx];
    endfunction

    // Expected MMIO read value for a request accepted on edge cb+1.
    function automatic logic [15:0] m_read(input logic [1:0] off, input int cb);
        case (off)
            2'd0:    return {8'h00, m_led};
            2'd1:    return {8'h00, m_sw(cb)};
            2'd2:    return 16'(cb - clr_edge);
            default: return {15'b0, m_err};
        endcase
    endfunction

    function automatic logic [15:0] ext_addr_rand();
        return 16'($urandom_range(0, 16'hFFEF));
    endfunction

    // ---------------- driver tasks (start and end at a negedge) ----------------
    task automatic mmio_op(input logic re, input logic we, input logic [1:0] off,
                           input logic [15:0] wdata, input string tag);
        int          cb;
        logic [15:0] e;
        cb = cyc;
        bus.req_re    = re;
        bus.req_we    = we;
        bus.req_addr  = 16'hFFF0 | {14'b0, off};
        bus.req_wdata = wdata;
        e = m_read(off, cb);
        @(negedge clock);
        bus.req_re = 1'b0;
        bus.req_we = 1'b0;
        if (we) begin
            case (off)
                2'd0:    m_led = wdata[7:0];
                2'd2:    clr_edge = cb + 1;
                2'd3:    if (wdata[0]) m_err = 1'b0;
                default: ;
            endcase
        end else begin
            m_rdata = e;
        end
        exp_q.push_back(m_rdata);
        check_eq({tag, "_rdata"}, bus.rdata, exp_q.pop_front());
        check_eq({tag, "_busy"}, bus.busy, 1'b0);
        check_eq({tag, "_led"}, led_out, m_led);
    endtask

    task automatic ext_op(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                          input int delay, input int hold, input bit pulse, input string tag);
        logic [15:0] rd;
        bus.req_re    = !we;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(negedge clock);
        bus.req_re = 1'b0;
        bus.req_we = 1'b0;
        check_eq({tag, "_req_up"}, bus.ext_req, 1'b1);
        check_eq({tag, "_busy_up"}, bus.busy, 1'b1);
        check_eq({tag, "_ext_we"}, bus.ext_we, we);
        check_eq({tag, "_ext_addr"}, bus.ext_addr, addr);
        if (we) check_eq({tag, "_ext_wdata"}, bus.ext_wdata, wdata);
        if (pulse) begin
            // A store to the LED register while busy must be ignored.
            bus.req_we    = 1'b1;
            bus.req_addr  = 16'hFFF0;
            bus.req_wdata = {8'h00, ~m_led};
        end
        for (int i = 1; i < delay; i++) begin
            @(negedge clock);
            bus.req_we = 1'b0;
            check_eq({tag, "_req_hold"}, bus.ext_req, 1'b1);
        end
        bus.req_we = 1'b0;
        if (!we) begin
            if (!mem.exists(int'(addr))) mem[int'(addr)] = 16'($urandom);
            rd = mem[int'(addr)];
        end else begin
            rd = 16'($urandom);
            mem[int'(addr)] = wdata;
        end
        bus.ext_ack   = 1'b1;
        bus.ext_rdata = rd;
        @(negedge clock);
        if (!we) m_rdata = rd;
        check_eq({tag, "_req_down"}, bus.ext_req, 1'b0);
        check_eq({tag, "_rdata"}, bus.rdata, m_rdata);
        check_eq({tag, "_busy_rel"}, bus.busy, 1'b1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            check_eq({tag, "_busy_hold"}, bus.busy, 1'b1);
        end
        bus.ext_ack   = 1'b0;
        bus.ext_rdata = 16'h0000;
        @(negedge clock);
        check_eq({tag, "_busy_down"}, bus.busy, 1'b0);
        check_eq({tag, "_led"}, led_out, m_led);
    endtask

    task automatic timeout_op(input logic we, input logic [15:0] addr,
                              input logic [15:0] wdata, input string tag);
        bus.req_re    = !we;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(negedge clock);
        bus.req_re = 1'b0;
        bus.req_we = 1'b0;
        check_eq({tag, "_req_up"}, bus.ext_req, 1'b1);
        for (int k = 1; k <= TO; k++) begin
            @(negedge clock);
            check_eq({tag, "_req_hold"}, bus.ext_req, 1'b1);
        end
        @(negedge clock);
        m_err = 1'b1;
        if (!we) m_rdata = TIMEOUT_DATA;
        check_eq({tag, "_req_down"}, bus.ext_req, 1'b0);
        check_eq({tag, "_rdata"}, bus.rdata, m_rdata);
        check_eq({tag, "_busy_rel"}, bus.busy, 1'b1);
        @(negedge clock);
        check_eq({tag, "_busy_down"}, bus.busy, 1'b0);
    endtask

    task automatic model_reset();
        rst_rel  = cyc;
        clr_edge = cyc;
        m_led    = 8'h00;
        m_err    = 1'b0;
        m_rdata  = 16'h0000;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus.req_re    = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 16'h0000;
        bus.req_wdata = 16'h0000;
        bus.ext_ack   = 1'b0;
        bus.ext_rdata = 16'h0000;
        sw_in         = 8'h00;

        repeat (3) @(negedge clock);
        check_eq("rst_rdata", bus.rdata, 16'h0000);
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_ext_req", bus.ext_req, 1'b0);
        check_eq("rst_ext_we", bus.ext_we, 1'b0);
        check_eq("rst_ext_addr", bus.ext_addr, 16'h0000);
        check_eq("rst_ext_wdata", bus.ext_wdata, 16'h0000);
        check_eq("rst_led", led_out, 8'h00);
        check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
        reset = 1'b1;
        model_reset();

        // LED store then load
        mmio_op(1'b0, 1'b1, 2'd0, 16'h00A5, "led_wr");
        check_eq("led_a5", led_out, 8'hA5);
        mmio_op(1'b1, 1'b0, 2'd0, 16'h0000, "led_rd");
        check_eq("led_rd_a5", bus.rdata, 16'h00A5);

        // External load, ack 3 cycles after ext_req, with an ignored mid-access request
        mem[16'h0123] = 16'hBEEF;
        ext_op(1'b0, 16'h0123, 16'h0000, 3, 1, 1'b1, "ext_beef");
        check_eq("ext_beef_val", bus.rdata, 16'hBEEF);
        // Minimum latency store and load
        ext_op(1'b1, 16'h0042, 16'h5A5A, 1, 0, 1'b0, "ext_min_st");
        ext_op(1'b0, 16'h0042, 16'h0000, 1, 0, 1'b0, "ext_min_ld");
        check_eq("ext_min_val", bus.rdata, 16'h5A5A);
        // Ack on the very last allowed edge still completes
        ext_op(1'b0, 16'h0077, 16'h0000, TO + 1, 0, 1'b0, "ext_late");

        // Timeout, status read, clear
        timeout_op(1'b0, 16'h0200, 16'h0000, "to_ld");
        check_eq("to_dead", bus.rdata, 16'hDEAD);
        mmio_op(1'b1, 1'b0, 2'd3, 16'h0000, "stat_rd1");
        check_eq("stat_err1", bus.rdata, 16'h0001);
        mmio_op(1'b0, 1'b1, 2'd3, 16'h0001, "stat_clr");
        mmio_op(1'b1, 1'b0, 2'd3, 16'h0000, "stat_rd0");
        check_eq("stat_err0", bus.rdata, 16'h0000);

        // Counter clear and count
        mmio_op(1'b0, 1'b1, 2'd2, 16'h1234, "cnt_clr");
        repeat (3) @(negedge clock);
        mmio_op(1'b1, 1'b0, 2'd2, 16'h0000, "cnt_rd");
        check_eq("cnt_3", bus.rdata, 16'h0003);

        // Both strobes: store wins
        mmio_op(1'b1, 1'b1, 2'd0, 16'h003C, "both");
        check_eq("both_led", led_out, 8'h3C);

        // Switch write ignored; synchronizer latency
        mmio_op(1'b0, 1'b1, 2'd1, 16'h00FF, "sw_wr");
        sw_in = 8'h5A;
        mmio_op(1'b1, 1'b0, 2'd1, 16'h0000, "sw_rd0");
        mmio_op(1'b1, 1'b0, 2'd1, 16'h0000, "sw_rd1");
        mmio_op(1'b1, 1'b0, 2'd1, 16'h0000, "sw_rd2");
        check_eq("sw_5a", bus.rdata, 16'h005A);

        // Asynchronous reset in the middle of REQ
        mmio_op(1'b0, 1'b1, 2'd0, 16'h0077, "pre_rst_wr");
        mmio_op(1'b1, 1'b0, 2'd0, 16'h0000, "pre_rst_rd");
        bus.req_re   = 1'b1;
        bus.req_addr = 16'h0400;
        @(negedge clock);
        bus.req_re = 1'b0;
        check_eq("mid_req_up", bus.ext_req, 1'b1);
        #3;
        reset = 1'b0;
        #1;
        check_eq("mid_rst_ext_req", bus.ext_req, 1'b0);
        check_eq("mid_rst_busy", bus.busy, 1'b0);
        check_eq("mid_rst_rdata", bus.rdata, 16'h0000);
        check_eq("mid_rst_led", led_out, 8'h00);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        mmio_op(1'b1, 1'b0, 2'd2, 16'h0000, "post_rst_cnt");

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            int op;
            if ($urandom_range(0, 1) == 1) sw_in = 8'($urandom);
            op = $urandom_range(0, 6);
            case (op)
                0, 1: mmio_op(1'b1, 1'b0, 2'($urandom_range(0, 3)), 16'h0000, "r_rd");
                2:    mmio_op(1'b0, 1'b1, 2'($urandom_range(0, 3)), 16'($urandom), "r_wr");
                3:    mmio_op(1'b1, 1'b1, 2'($urandom_range(0, 3)), 16'($urandom), "r_both");
                4:    ext_op(1'b0, ext_addr_rand(), 16'h0000, $urandom_range(1, TO + 1),
                             $urandom_range(0, 2), 1'($urandom_range(0, 1)), "r_ext_ld");
                5:    ext_op(1'b1, ext_addr_rand(), 16'($urandom), $urandom_range(1, TO + 1),
                             $urandom_range(0, 2), 1'($urandom_range(0, 1)), "r_ext_st");
                default: timeout_op(1'($urandom_range(0, 1)), ext_addr_rand(), 16'($urandom), "r_to");
            endcase
            if ($urandom_range(0, 3) == 0) @(negedge clock);
        end

        // Counter wraparound
        mmio_op(1'b0, 1'b1, 2'd2, 16'h0000, "wrap_clr");
        repeat (65535) @(negedge clock);
        mmio_op(1'b1, 1'b0, 2'd2, 16'h0000, "wrap_ffff");
        check_eq("wrap_ffff_val", bus.rdata, 16'hFFFF);
        mmio_op(1'b1, 1'b0, 2'd2, 16'h0000, "wrap_zero");
        check_eq("wrap_zero_val", bus.rdata, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Data-memory responder for the multicycle CPU. It serves the load/store strobes that the control FSM raises in WRITE BACK: it returns load data to the write-back mux and accepts store data. Addresses in a small MMIO window hit local registers (LEDs, switches, cycle counter, status) in one cycle. All other addresses go to external SRAM over a 4-phase req/ack handshake with a timeout, and `busy` tells the control FSM to hold.

## Interface
Parameters:
- `TIMEOUT`, 255: max cycles waiting for `ext_ack` before the access is aborted.
- `MMIO_BASE`, 16'hFFF0: base of the 4-word local window (`MMIO_BASE`..`MMIO_BASE+3`).

Ports (name, direction, width, meaning):
- `clock`, in, 1: sole clock, rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `req_re`, in, 1: load request from the CPU.
- `req_we`, in, 1: store request from the CPU (`brWe`).
- `req_addr`, in, 16: word address.
- `req_wdata`, in, 16: store data.
- `rdata`, out, 16: registered load data.
- `busy`, out, 1: access in progress; the CPU must hold its request and not advance.
- `ext_req`, out, 1: SRAM request, 4-phase.
- `ext_we`, out, 1: SRAM write enable, valid while `ext_req`=1.
- `ext_addr`, out, 16: SRAM address, held while `ext_req`=1.
- `ext_wdata`, out, 16: SRAM write data, held while `ext_req`=1.
- `ext_ack`, in, 1: SRAM acknowledge.
- `ext_rdata`, in, 16: SRAM read data, valid when `ext_ack`=1.
- `sw_in`, in, 8: asynchronous board switches.
- `led_out`, out, 8: LED register.

## Operation
- States: IDLE, REQ, RELEASE. `busy` = (state != IDLE), decoded from the registered state.
- **IDLE.** A request is accepted on any edge where `req_re|req_we`=1.
  - If both strobes are set, the access is a store and the load is ignored.
  - MMIO hit (`req_addr[15:2]` == `MMIO_BASE[15:2]`): the access completes at that edge and the state stays IDLE.
  - Otherwise: latch address, data and write flag onto the `ext_*` outputs, set `ext_req`=1, go to REQ, clear the timeout counter.
- **REQ.**
  - On `ext_ack`=1: load `rdata` from `ext_rdata` (loads only), drop `ext_req`, go to RELEASE.
  - Otherwise the timeout counter increments. When it reaches `TIMEOUT`: drop `ext_req`, set `rdata`=16'hDEAD for loads, set `err`, go to RELEASE.
- **RELEASE.** Stay until `ext_ack`=0, then go to IDLE.
- Requests are ignored while `busy`=1.
- **MMIO map** (offset from `MMIO_BASE`):
  - +0: LED register, R/W; `led_out` = reg[7:0]; reads return {8'h00, reg}.
  - +1: switches, read-only; {8'h00, `sw_in` after a 2-flop synchronizer}; writes are ignored.
  - +2: 16-bit cycle counter, +1 every cycle, wraps 16'hFFFF→0. A write clears it to 0 and beats the increment on the same edge. A read returns the pre-edge value.
  - +3: status, {14'b0, `busy`, `err`}. `busy` always reads 0 here. Writing 1 to bit0 clears `err`. A timeout on the same edge as the clear wins, so `err` stays 1.
- **Stores** leave `rdata` unchanged.
- **Reset** (`reset`=0, asynchronous, including mid-handshake): state IDLE, `ext_req`=0, `ext_we`=0, `ext_addr`=0, `ext_wdata`=0, `rdata`=0, LED=0, counter=0, `err`=0, synchronizer flops 0, `busy`=0.

## Timing
- **MMIO load:** request at edge N; `rdata` valid after N; `busy` never rises.
- **External access:** accepted at N; `ext_req`=1 and `busy`=1 after N.
  - If `ext_ack` is sampled at edge N+k: `rdata` is valid and `ext_req`=0 after N+k.
  - `busy` falls one edge after `ext_ack` is sampled low.
  - Minimum external latency (ack at N+1, released at N+2): `busy` high for 2 cycles.
- **Timeout:** `ext_req` drops after edge N+`TIMEOUT`+1 if `ext_ack` never rose.
- **Switches:** a change appears in reads 2 edges after it.
- All outputs are registered except `busy`.

## Structure
- Package `mem_responder_pkg`: state enum (IDLE, REQ, RELEASE), MMIO offset constants (LED=0, SW=1, CNT=2, STAT=3), `TIMEOUT_DATA` = 16'hDEAD.
- Sub-module `sync2`: 8-bit two-flop synchronizer for `sw_in`, same async active-low reset.
- Everything else (FSM, timeout counter, MMIO registers) lives in `mem_responder`.

## Test plan
- Reset mid-REQ with `ext_req`=1 → `ext_req`=0, `busy`=0, `rdata`=0, `led_out`=0 immediately.
- Store 16'h00A5 to 16'hFFF0, then load 16'hFFF0 → `led_out`=8'hA5, `rdata`=16'h00A5 after one edge, `busy` stays 0.
- Load 16'h0123 with `ext_ack` raised 3 cycles after `ext_req` and `ext_rdata`=16'hBEEF → `rdata`=16'hBEEF. `ext_req` falls the edge after ack. `busy` falls one edge after ack drops. A request pulsed mid-access is ignored.
- `TIMEOUT`=4, load 16'h0200 with no ack → `ext_req` drops after 5 REQ edges, `rdata`=16'hDEAD, status reads 16'h0001. Write 16'h0001 to 16'hFFF3 → status reads 16'h0000.
- Write 16'h1234 to 16'hFFF2, idle 3 cycles, then read → 16'h0003. Run the counter from 16'hFFFF → it reads 16'h0000 on the following edge.
- `req_re` and `req_we` both set, address 16'hFFF0, `req_wdata`=16'h003C → treated as a store: `led_out`=8'h3C, `rdata` unchanged.
